// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - debug engine that stalls the pipeline and streams a register range out
module regfile_dump #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic              stall_req,
   input  logic              stall_ack,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_last,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_ACK = 3'd1,
      S_READ     = 3'd2,
      S_HOLD     = 3'd3,
      S_FIN      = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [ADDR_W-1:0] lim_q, lim_d;
   logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
   logic [DATA_W-1:0] dump_data_q, dump_data_d;
   logic              dump_last_q, dump_last_d;
   logic              err_q, err_d;

   logic start_ok;
   logic start_bad;
   logic handshake;

   // Start is only honoured in IDLE; an inverted range is refused with an err pulse.
   always_comb begin
      start_ok  = (state_q == S_IDLE) && start && (first_addr <= last_addr);
      start_bad = (state_q == S_IDLE) && start && (first_addr >  last_addr);
      handshake = (state_q == S_HOLD) && dump_ready;
   end

   // State and datapath registers, cleared asynchronously so a mid-dump reset is immediate.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         lim_q       <= '0;
         dump_addr_q <= '0;
         dump_data_q <= '0;
         dump_last_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         lim_q       <= lim_d;
         dump_addr_q <= dump_addr_d;
         dump_data_q <= dump_data_d;
         dump_last_q <= dump_last_d;
         err_q       <= err_d;
      end
   end

   // Next-state logic: the walk alternates READ/HOLD until the word flagged last is taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (start_ok)  state_d = S_WAIT_ACK;
         S_WAIT_ACK: if (stall_ack) state_d = S_READ;
         S_READ:     state_d = S_HOLD;
         S_HOLD:     if (handshake) state_d = dump_last_q ? S_FIN : S_READ;
         S_FIN:      state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Datapath: latch the range, capture the read word, and advance only after a non-last handshake
   // so that a range ending at 31 never wraps the cursor back to 0.
   always_comb begin
      cur_d       = cur_q;
      lim_d       = lim_q;
      dump_addr_d = dump_addr_q;
      dump_data_d = dump_data_q;
      dump_last_d = dump_last_q;
      err_d       = start_bad;
      if (start_ok) begin
         cur_d = first_addr;
         lim_d = last_addr;
      end
      if (state_q == S_READ) begin
         dump_addr_d = cur_q;
         dump_data_d = (cur_q == '0) ? '0 : rd_data;
         dump_last_d = (cur_q == lim_q);
      end
      if (handshake && !dump_last_q) begin
         cur_d = cur_q + 1'b1;
      end
   end

   // Output decode: stall and RS1 ownership span WAIT_ACK through HOLD and drop in FIN.
   always_comb begin
      busy       = (state_q == S_WAIT_ACK) || (state_q == S_READ) || (state_q == S_HOLD);
      stall_req  = busy;
      rd_addr    = busy ? cur_q : '0;
      dump_valid = (state_q == S_HOLD);
      done       = (state_q == S_FIN);
      err        = err_q;
      dump_addr  = dump_addr_q;
      dump_data  = dump_data_q;
      dump_last  = dump_last_q;
   end

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - directed self-checking bench for regfile_dump
module tb_regfile_dump;

   logic        clk;
   logic        reset;
   logic        start;
   logic [4:0]  first_addr;
   logic [4:0]  last_addr;
   logic        stall_req;
   logic        stall_ack;
   logic [4:0]  rd_addr;
   logic [63:0] rd_data;
   logic        dump_valid;
   logic        dump_ready;
   logic [4:0]  dump_addr;
   logic [63:0] dump_data;
   logic        dump_last;
   logic        busy;
   logic        done;
   logic        err;

   logic [63:0] regs [32];

   int n_tests = 0;
   int n_fail  = 0;

   regfile_dump #(.DATA_W(64), .ADDR_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .stall_req  (stall_req),
      .stall_ack  (stall_ack),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .dump_last  (dump_last),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // Combinational register-file read port model.
   assign rd_data = regs[rd_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_default();
      for (int i = 0; i < 32; i++) regs[i] = 64'd0;
      regs[18] = 64'd10;
      regs[20] = 64'd5;
      regs[21] = 64'd1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, {63'd0, stall_req}, 64'd0);
      check({tag, "_busy"},  {63'd0, busy},      64'd0);
      check({tag, "_valid"}, {63'd0, dump_valid},64'd0);
      check({tag, "_last"},  {63'd0, dump_last}, 64'd0);
      check({tag, "_done"},  {63'd0, done},      64'd0);
      check({tag, "_err"},   {63'd0, err},       64'd0);
      check({tag, "_rdaddr"},{59'd0, rd_addr},   64'd0);
      check({tag, "_daddr"}, {59'd0, dump_addr}, 64'd0);
      check({tag, "_ddata"}, dump_data,          64'd0);
   endtask

   // Pulse start for one cycle; on return the DUT has seen the edge.
   task automatic do_start(input logic [4:0] f, input logic [4:0] l);
      start      = 1'b1;
      first_addr = f;
      last_addr  = l;
      tick();
      start      = 1'b0;
   endtask

   // Entered at a negedge with the first word of [f..l] already valid; ready must be 1.
   task automatic drain(input string tag, input int f, input int l);
      for (int i = f; i <= l; i++) begin
         check({tag, "_valid"}, {63'd0, dump_valid}, 64'd1);
         check({tag, "_addr"},  {59'd0, dump_addr},  64'(i));
         check({tag, "_data"},  dump_data,           (i == 0) ? 64'd0 : regs[i]);
         check({tag, "_last"},  {63'd0, dump_last},  (i == l) ? 64'd1 : 64'd0);
         check({tag, "_stall"}, {63'd0, stall_req},  64'd1);
         tick();
         if (i != l) begin
            check({tag, "_gap"}, {63'd0, dump_valid}, 64'd0);
            tick();
         end
      end
      check({tag, "_done"},      {63'd0, done},       64'd1);
      check({tag, "_fin_stall"}, {63'd0, stall_req},  64'd0);
      check({tag, "_fin_busy"},  {63'd0, busy},       64'd0);
      check({tag, "_fin_valid"}, {63'd0, dump_valid}, 64'd0);
      tick();
      check({tag, "_done_off"},  {63'd0, done},       64'd0);
      check({tag, "_idle_busy"}, {63'd0, busy},       64'd0);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      first_addr = 5'd0;
      last_addr  = 5'd0;
      stall_ack  = 1'b0;
      dump_ready = 1'b0;
      load_default();
      #1 reset = 1'b0;

      // Reset state, also held across a clock edge.
      @(negedge clk);
      check_all_zero("rst");
      tick();
      check_all_zero("rst_edge");
      reset = 1'b1;
      tick();

      // Basic range 18..21 with ack and ready tied high.
      stall_ack  = 1'b1;
      dump_ready = 1'b1;
      do_start(5'd18, 5'd21);
      check("t1_wait_stall", {63'd0, stall_req}, 64'd1);
      check("t1_wait_busy",  {63'd0, busy},      64'd1);
      check("t1_wait_valid", {63'd0, dump_valid},64'd0);
      tick();
      check("t1_read_rdaddr", {59'd0, rd_addr},   64'd18);
      check("t1_read_valid",  {63'd0, dump_valid},64'd0);
      tick();
      drain("t1", 18, 21);

      // Full range with x0 holding garbage inside the register file.
      for (int i = 0; i < 32; i++) regs[i] = 64'hA5A5_0000_0000_0000 | 64'(i * 7);
      regs[0] = 64'hDEAD;
      do_start(5'd0, 5'd31);
      tick();
      tick();
      drain("full", 0, 31);
      check("full_cur_nowrap", {59'd0, rd_addr}, 64'd0);
      load_default();

      // Inverted range is rejected.
      do_start(5'd5, 5'd3);
      check("err_pulse", {63'd0, err},        64'd1);
      check("err_stall", {63'd0, stall_req},  64'd0);
      check("err_busy",  {63'd0, busy},       64'd0);
      check("err_valid", {63'd0, dump_valid}, 64'd0);
      tick();
      check("err_off",   {63'd0, err},        64'd0);
      check("err_stay",  {63'd0, busy},       64'd0);

      // Backpressure on word 20.
      do_start(5'd18, 5'd21);
      tick();
      tick();
      for (int i = 18; i < 20; i++) begin
         check("bp_addr", {59'd0, dump_addr}, 64'(i));
         tick();
         tick();
      end
      dump_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("bp_hold_valid", {63'd0, dump_valid}, 64'd1);
         check("bp_hold_addr",  {59'd0, dump_addr},  64'd20);
         check("bp_hold_data",  dump_data,           64'd5);
         tick();
      end
      check("bp_hold_final", {59'd0, dump_addr}, 64'd20);
      dump_ready = 1'b1;
      tick();
      check("bp_release_gap", {63'd0, dump_valid}, 64'd0);
      tick();
      drain("bp_tail", 21, 21);

      // Delayed acknowledge with a stray second start during WAIT_ACK.
      stall_ack = 1'b0;
      do_start(5'd18, 5'd21);
      for (int k = 0; k < 6; k++) begin
         check("ack_stall", {63'd0, stall_req},  64'd1);
         check("ack_busy",  {63'd0, busy},       64'd1);
         check("ack_valid", {63'd0, dump_valid}, 64'd0);
         if (k == 2) begin
            start      = 1'b1;
            first_addr = 5'd0;
            last_addr  = 5'd1;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start     = 1'b0;
      stall_ack = 1'b1;
      tick();
      check("ack_lat1", {63'd0, dump_valid}, 64'd0);
      tick();
      drain("ack", 18, 21);

      // Asynchronous reset while holding word 19.
      regs[0] = 64'hDEAD;
      do_start(5'd18, 5'd21);
      tick();
      tick();
      check("ar_w18", {59'd0, dump_addr}, 64'd18);
      tick();
      tick();
      check("ar_w19_addr",  {59'd0, dump_addr},  64'd19);
      check("ar_w19_valid", {63'd0, dump_valid}, 64'd1);
      dump_ready = 1'b0;
      #2 reset = 1'b0;
      #1 check_all_zero("ar_async");
      tick();
      check_all_zero("ar_held");
      reset      = 1'b1;
      dump_ready = 1'b1;
      tick();
      check("ar_no_done", {63'd0, done}, 64'd0);
      do_start(5'd0, 5'd3);
      tick();
      tick();
      drain("ar_fresh", 0, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
